// File: rtl/memory_write_controller.sv
// memory_write_controller
//   Turns slide-switch data/address and raw push-buttons into clean data/addr/store drive
//   for the 4x8 byte-memory array. Buttons are synchronized and debounced. data/addr are
//   frozen around a fixed-width store pulse. A clear-all sequence zeroes bytes 0..3.
//   Optional feature macro: AUTO_INC_EN. When it is defined, store presses ignore sw_addr
//   and the address advances after every store write.

// Debounce lane for one button: a 2-flop synchronizer feeding an accepted-level filter.
module mwc_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;
    logic          smp;

    assign smp = sync_pipe[1];

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[0], raw};
    end

    // Flip the accepted level after DEBOUNCE_CYCLES contrary samples; any agreeing sample restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (smp != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= smp;
                    cnt   <= '0;
                    press <= smp;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module memory_write_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STORE_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sw_data,
    input  logic [1:0] sw_addr,
    input  logic       btn_store,
    input  logic       btn_clear,
    output logic [7:0] data,
    output logic [1:0] addr,
    output logic       store,
    output logic       busy
);
    localparam int NUM_BTN = 2;
    localparam int BTN_ST  = 0;
    localparam int BTN_CLR = 1;
    localparam int PW      = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] addr;
    } wr_t;

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, HOLD, NEXT, WAIT_REL
    } state_t;

    state_t               state_q, state_d;
    wr_t                  wr_q, wr_d;
    wr_t                  sw_s1, sw_s2;
    logic                 store_q, store_d;
    logic                 clr_q, clr_d;
    logic [NUM_BTN-1:0]   src_q, src_d;
    logic [PW-1:0]        pcnt;
    logic [NUM_BTN-1:0]   btn_raw, btn_lvl, btn_prs;

    assign btn_raw = {btn_clear, btn_store};

    mwc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_raw),
        .level   (btn_lvl),
        .press   (btn_prs)
    );

    // Synchronize the switch bank so captured values are never mid-transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= '{data: sw_data, addr: sw_addr};
            sw_s2 <= sw_s1;
        end
    end

    // State register and pulse-width counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pcnt    <= '0;
        end else begin
            state_q <= state_d;
            pcnt    <= (state_q == PULSE) ? pcnt + 1'b1 : '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (|btn_prs) state_d = SETUP;
            SETUP:    state_d = PULSE;
            PULSE:    if (pcnt == PW'(STORE_CYCLES - 1)) state_d = HOLD;
            HOLD:     state_d = (clr_q && wr_q.addr != 2'd3) ? NEXT : WAIT_REL;
            NEXT:     state_d = SETUP;
            WAIT_REL: if ((src_q & btn_lvl) == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered data/addr/store/clr drive
    always_comb begin
        wr_d    = wr_q;
        clr_d   = clr_q;
        src_d   = src_q;
        store_d = (state_d == PULSE);
        case (state_q)
            IDLE: begin
                if (btn_prs[BTN_CLR]) begin
                    // clear wins over a simultaneous store press
                    wr_d  = '0;
                    clr_d = 1'b1;
                    src_d = btn_prs;
                end else if (btn_prs[BTN_ST]) begin
                    wr_d.data = sw_s2.data;
`ifdef AUTO_INC_EN
                    wr_d.addr = wr_q.addr;
`else
                    wr_d.addr = sw_s2.addr;
`endif
                    clr_d = 1'b0;
                    src_d = btn_prs;
                end
            end
`ifdef AUTO_INC_EN
            HOLD: begin
                // advance after a store write; a finished clear-all returns to byte 0
                if (state_d == WAIT_REL)
                    wr_d.addr = clr_q ? 2'd0 : wr_q.addr + 2'd1;
            end
`endif
            NEXT: wr_d.addr = wr_q.addr + 2'd1;
            WAIT_REL: begin
                if (state_d == IDLE) begin
                    clr_d = 1'b0;
                    src_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset drops store immediately even mid-pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            store_q <= 1'b0;
            clr_q   <= 1'b0;
            src_q   <= '0;
        end else begin
            wr_q    <= wr_d;
            store_q <= store_d;
            clr_q   <= clr_d;
            src_q   <= src_d;
        end
    end

    assign data  = wr_q.data;
    assign addr  = wr_q.addr;
    assign store = store_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_memory_write_controller.sv
// Directed bench for memory_write_controller (DEBOUNCE_CYCLES=4, STORE_CYCLES=2).
// Build with AUTO_INC_EN defined to run the auto-increment scenario instead of 2..5.
module tb_memory_write_controller;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sw_data;
    logic [1:0] sw_addr;
    logic       btn_store, btn_clear;
    logic [7:0] data;
    logic [1:0] addr;
    logic       store, busy;

    int n_cmp = 0;
    int n_bad = 0;

    memory_write_controller #(.DEBOUNCE_CYCLES(4), .STORE_CYCLES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_data   (sw_data),
        .sw_addr   (sw_addr),
        .btn_store (btn_store),
        .btn_clear (btn_clear),
        .data      (data),
        .addr      (addr),
        .store     (store),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // pulse log: one entry per store pulse, with its data/addr and width
    logic [7:0] pd [0:31];
    logic [1:0] pa [0:31];
    int         pw [0:31];
    int         np = 0;
    int         width = 0;
    int         serr = 0;
    logic       store_prev = 1'b0;
    logic [9:0] last_da = '0;

    always @(negedge clk) begin
        if (store) begin
            if (!store_prev) begin
                if (np < 32) begin
                    pd[np] = data;
                    pa[np] = addr;
                end
                width = 1;
            end else begin
                width = width + 1;
                if ({data, addr} != last_da) serr = serr + 1;
            end
            last_da = {data, addr};
        end else if (store_prev) begin
            if (np < 32) pw[np] = width;
            np = np + 1;
        end
        store_prev = store;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // cycles until store is seen high, 0 on timeout
    task automatic wait_store(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (store) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            cyc(1);
        end
        chk(tag, busy, 0);
    endtask

    int base, lat, s0;

    initial begin
        reset_n = 1'b0; sw_data = 8'h00; sw_addr = 2'd0;
        btn_store = 1'b0; btn_clear = 1'b0;

        // 1: reset values, then reset in the middle of a pulse
        cyc(3);
        chk("rst_data", data, 8'h00);
        chk("rst_addr", addr, 2'd0);
        chk("rst_store", store, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        cyc(3);
        chk("rel_busy", busy, 0);

`ifndef AUTO_INC_EN
        sw_data = 8'h3C; sw_addr = 2'd1;
        cyc(3);
        btn_store = 1'b1;
        wait_store(lat);
        chk("rstp_seen", lat, 8);
        reset_n = 1'b0;
        #1;
        chk("rstp_store", store, 0);
        chk("rstp_data", data, 8'h00);
        btn_store = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(10);

        // 2: clean press, switches toggled during the pulse
        sw_data = 8'hA5; sw_addr = 2'd2;
        cyc(3);
        base = np; s0 = serr;
        btn_store = 1'b1;
        wait_store(lat);
        chk("t2_latency", lat, 8);
        chk("t2_busy", busy, 1);
        sw_data = 8'hFF; sw_addr = 2'd0;
        cyc(8);
        btn_store = 1'b0;
        wait_idle("t2_idle");
        cyc(2);
        chk("t2_count", np - base, 1);
        chk("t2_data", pd[base], 8'hA5);
        chk("t2_addr", pa[base], 2'd2);
        chk("t2_width", pw[base], 2);
        chk("t2_stable", serr - s0, 0);
        chk("t2_hold_data", data, 8'hA5);
        chk("t2_hold_addr", addr, 2'd2);

        // 3: bouncy press and bouncy release
        sw_data = 8'h5A; sw_addr = 2'd1;
        cyc(3);
        base = np;
        btn_store = 1'b1; cyc(1); btn_store = 1'b0; cyc(1);
        btn_store = 1'b1; cyc(1); btn_store = 1'b0; cyc(1);
        btn_store = 1'b1; cyc(30);
        btn_store = 1'b0; cyc(1); btn_store = 1'b1; cyc(1);
        btn_store = 1'b0; cyc(1); btn_store = 1'b1; cyc(1);
        btn_store = 1'b0;
        wait_idle("t3_idle");
        cyc(20);
        chk("t3_count", np - base, 1);
        chk("t3_data", pd[base], 8'h5A);
        chk("t3_addr", pa[base], 2'd1);

        // 4: clear-all with a store press mid-sequence
        sw_data = 8'h77; sw_addr = 2'd2;
        cyc(3);
        base = np;
        btn_clear = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) cyc(1);
        chk("t4_start", busy, 1);
        begin
            int lows = 0;
            for (int i = 0; i < 25; i++) begin
                if (i == 5)  btn_store = 1'b1;
                if (i == 15) btn_store = 1'b0;
                if (!busy) lows++;
                cyc(1);
            end
            chk("t4_busy", lows, 0);
        end
        btn_clear = 1'b0;
        wait_idle("t4_idle");
        cyc(20);
        chk("t4_count", np - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_addr%0d", i), pa[base + i], i);
            chk($sformatf("t4_data%0d", i), pd[base + i], 8'h00);
            chk($sformatf("t4_width%0d", i), pw[base + i], 2);
        end
        chk("t4_end_addr", addr, 2'd3);

        // 5: store and clear accepted together
        sw_data = 8'hC3; sw_addr = 2'd2;
        cyc(3);
        base = np;
        btn_store = 1'b1; btn_clear = 1'b1;
        cyc(40);
        btn_store = 1'b0; btn_clear = 1'b0;
        wait_idle("t5_idle");
        cyc(5);
        chk("t5_count", np - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_addr%0d", i), pa[base + i], i);
            chk($sformatf("t5_data%0d", i), pd[base + i], 8'h00);
        end
`else
        // 6: auto-increment fills 0,1,2,3 then wraps to 0, sw_addr ignored
        sw_addr = 2'd3;
        base = np;
        for (int i = 0; i < 5; i++) begin
            sw_data = 8'h10 + 8'(i);
            cyc(3);
            btn_store = 1'b1;
            cyc(15);
            btn_store = 1'b0;
            wait_idle($sformatf("t6_idle%0d", i));
            cyc(3);
        end
        chk("t6_count", np - base, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t6_addr%0d", i), pa[base + i], i % 4);
            chk($sformatf("t6_data%0d", i), pd[base + i], 8'h10 + i);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
